fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: NOP_INST, default 32'h0000_0013 (addi x0,x0,0), bubble value driven on instOut.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 imemReq  output  1  instruction-memory request; held until imemValid.
REQ-006 imemAddr  output  32  request address, word-aligned, stable while imemReq high.
REQ-007 imemValid  input  1  one-cycle response strobe for the outstanding request.
REQ-008 imemData  input  32  instruction word, qualified by imemValid.
REQ-009 redirect  input  1  control-transfer from execute (branch/JAL/JALR taken).
REQ-010 redirectPc  input  32  redirect target.
REQ-011 stall  input  1  decode cannot accept; IF/ID contents must hold.
REQ-012 instValid  output  1  instOut/pcOut hold a live instruction.
REQ-013 instOut  output  32  IF/ID instruction word, feeds decode and immediate generation.
REQ-014 pcOut  output  32  address of instOut.
REQ-015 opcodeOut  output  7  equals instOut[6:0], drives the immediate generator's opcode input.

Function
REQ-016 States: FETCH (request outstanding), HOLD (response parked in 1-entry skid buffer), DRAIN (stale request outstanding after redirect).
REQ-017 At most one request outstanding; imemAddr = reqAddr register, unchanged while imemReq=1.
REQ-018 FETCH + imemValid + (instValid=0 or stall=0): load instOut=imemData, pcOut=reqAddr, instValid=1 next cycle; reqAddr+=4; imemReq stays 1 with new address next cycle.
REQ-019 FETCH + imemValid + instValid=1 + stall=1: capture imemData/reqAddr into skid buffer, imemReq=0, go HOLD.
REQ-020 HOLD + stall=0: move buffer into IF/ID (instValid=1), reqAddr+=4, imemReq=1, go FETCH.
REQ-021 stall=0 with no new instruction available: instValid=0, instOut=NOP_INST next cycle.
REQ-022 stall=1: instOut, pcOut, instValid unchanged.
REQ-023 Latency: imemValid in cycle N -> instValid=1 in cycle N+1 (unstalled path).
REQ-024 redirect has priority over stall and imemValid: next cycle instValid=0, instOut=NOP_INST, skid buffer emptied.
REQ-025 redirect in HOLD, or in FETCH with imemValid=1 the same cycle: reqAddr={redirectPc[31:2],2'b00}, imemReq=1, go FETCH.
REQ-026 redirect in FETCH without imemValid: store target in pendPc, go DRAIN; imemReq/imemAddr unchanged.
REQ-027 DRAIN + imemValid: discard imemData, reqAddr=pendPc, go FETCH (new request next cycle).
REQ-028 redirect in DRAIN: overwrite pendPc; last target wins.
REQ-029 redirectPc[1:0] ignored (forced 0); PC arithmetic is modulo 2^32 (32'hFFFF_FFFC+4 wraps to 0).
REQ-030 opcodeOut is combinational from instOut; no other output is combinational from inputs.

Reset
REQ-031 rst=1 at an edge: state=FETCH, reqAddr=RESET_PC, imemReq=0, instValid=0, instOut=NOP_INST, pcOut=RESET_PC, skid buffer empty, pendPc=RESET_PC.
REQ-032 First cycle after rst deasserts: imemReq=1, imemAddr=RESET_PC.
REQ-033 rst mid-request abandons the outstanding request; an imemValid arriving while rst=1 is ignored.

Structure
REQ-034 Shared package holds: state enum (FETCH/HOLD/DRAIN), NOP_INST, RISC-V opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM), XLEN=32.
REQ-035 Single module, no sub-modules; skid buffer and IF/ID register inline.

Verification
REQ-036 Reset, memory returns 32'h00500093 one cycle after each request -> instValid=1 with pcOut=0, then pcOut=4, 8, ...; opcodeOut=7'b0010011.
REQ-037 stall=1 for 3 cycles while a response arrives -> HOLD, imemReq=0, IF/ID unchanged; on release, buffered word appears with pcOut+4 and fetch resumes.
REQ-038 redirect to 32'h0000_0102 while request to 32'h10 outstanding, response 2 cycles later -> response discarded, next imemAddr=32'h0000_0100, no instValid for 32'h10.
REQ-039 redirect and stall asserted together with instValid=1 -> next cycle instValid=0, instOut=32'h0000_0013.
REQ-040 reqAddr=32'hFFFF_FFFC fetched -> next imemAddr=32'h0000_0000.
REQ-041 rst asserted while in DRAIN with imemValid high -> outputs match REQ-031; first post-reset request at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM states, bubble encoding and RV32I major opcodes.
package fetch_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch with a 1-entry skid buffer feeding the IF/ID register.
// Latency: imemValid in cycle N gives instValid in N+1; stall parks one response and drops imemReq.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = fetch_unit_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemValid,
    input  logic [31:0] imemData,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    input  logic        stall,
    output logic        instValid,
    output logic [31:0] instOut,
    output logic [31:0] pcOut,
    output logic [6:0]  opcodeOut
);

    fetch_unit_pkg::state_e state_q, state_d;

    logic        imem_req_q,   imem_req_d;
    logic [31:0] req_addr_q,   req_addr_d;
    logic [31:0] pend_pc_q,    pend_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q,       inst_d;
    logic [31:0] pc_q,         pc_d;
    logic        skid_vld_q,   skid_vld_d;
    logic [31:0] skid_inst_q,  skid_inst_d;
    logic [31:0] skid_pc_q,    skid_pc_d;

    logic [31:0] redirect_tgt;
    logic        rsp_fire;
    logic        unused_redirect_lsb;

    assign redirect_tgt        = {redirectPc[31:2], 2'b00};
    assign unused_redirect_lsb = ^redirectPc[1:0];
    // A response only counts while our request is actually on the bus.
    assign rsp_fire            = imemValid && imem_req_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= fetch_unit_pkg::FETCH;
            imem_req_q   <= 1'b0;
            req_addr_q   <= RESET_PC;
            pend_pc_q    <= RESET_PC;
            inst_valid_q <= 1'b0;
            inst_q       <= NOP_INST;
            pc_q         <= RESET_PC;
            skid_vld_q   <= 1'b0;
            skid_inst_q  <= NOP_INST;
            skid_pc_q    <= RESET_PC;
        end else begin
            state_q      <= state_d;
            imem_req_q   <= imem_req_d;
            req_addr_q   <= req_addr_d;
            pend_pc_q    <= pend_pc_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            pc_q         <= pc_d;
            skid_vld_q   <= skid_vld_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        imem_req_d   = imem_req_q;
        req_addr_d   = req_addr_q;
        pend_pc_d    = pend_pc_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        pc_d         = pc_q;
        skid_vld_d   = skid_vld_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;

        // Bubble whenever decode drains and nothing new lands below.
        if (!stall) begin
            inst_valid_d = 1'b0;
            inst_d       = NOP_INST;
        end

        if (redirect) begin
            inst_valid_d = 1'b0;
            inst_d       = NOP_INST;
            skid_vld_d   = 1'b0;
            unique case (state_q)
                fetch_unit_pkg::FETCH: begin
                    if (imem_req_q && !imemValid) begin
                        pend_pc_d = redirect_tgt;
                        state_d   = fetch_unit_pkg::DRAIN;
                    end else begin
                        req_addr_d = redirect_tgt;
                        imem_req_d = 1'b1;
                    end
                end
                fetch_unit_pkg::DRAIN: begin
                    pend_pc_d = redirect_tgt;
                    if (imemValid) begin
                        req_addr_d = redirect_tgt;
                        imem_req_d = 1'b1;
                        state_d    = fetch_unit_pkg::FETCH;
                    end
                end
                default: begin
                    req_addr_d = redirect_tgt;
                    imem_req_d = 1'b1;
                    state_d    = fetch_unit_pkg::FETCH;
                end
            endcase
        end else begin
            unique case (state_q)
                fetch_unit_pkg::FETCH: begin
                    if (!imem_req_q) begin
                        imem_req_d = 1'b1;
                    end else if (rsp_fire) begin
                        if (!inst_valid_q || !stall) begin
                            inst_valid_d = 1'b1;
                            inst_d       = imemData;
                            pc_d         = req_addr_q;
                            req_addr_d   = req_addr_q + 32'd4;
                        end else begin
                            skid_vld_d  = 1'b1;
                            skid_inst_d = imemData;
                            skid_pc_d   = req_addr_q;
                            imem_req_d  = 1'b0;
                            state_d     = fetch_unit_pkg::HOLD;
                        end
                    end
                end
                fetch_unit_pkg::HOLD: begin
                    if (!stall) begin
                        inst_valid_d = 1'b1;
                        inst_d       = skid_inst_q;
                        pc_d         = skid_pc_q;
                        skid_vld_d   = 1'b0;
                        req_addr_d   = skid_pc_q + 32'd4;
                        imem_req_d   = 1'b1;
                        state_d      = fetch_unit_pkg::FETCH;
                    end
                end
                default: begin
                    if (imemValid) begin
                        req_addr_d = pend_pc_q;
                        imem_req_d = 1'b1;
                        state_d    = fetch_unit_pkg::FETCH;
                    end
                end
            endcase
        end
    end

    assign imemReq   = imem_req_q;
    assign imemAddr  = req_addr_q;
    assign instValid = inst_valid_q;
    assign instOut   = inst_q;
    assign pcOut     = pc_q;
    assign opcodeOut = inst_q[6:0];

endmodule
